// File: rtl/mem_router_pkg.sv
// Shared definitions for the memory router: write-path FSM encoding,
// structural limits and the slot-index width helper.
package mem_router_pkg;

   localparam int MAX_SLV    = 8;
   localparam int MAX_RD_LAT = 4;

   // Write path: IDLE passes CPU writes straight through, POSTED drains the
   // one-entry write buffer.
   typedef enum logic {
      WR_IDLE   = 1'b0,
      WR_POSTED = 1'b1
   } wr_state_t;

   // Width of a slot index; never below one bit so single-slave builds work.
   function automatic int slot_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_router_if.sv
// CPU-side and slave-side bus bundle of the memory router.
//
// Handshake: the CPU presents load or rd together with address/in. An access
// is accepted in any cycle where busy is low; while busy is high the CPU keeps
// address, in, load and rd unchanged. busy is combinational in the same cycle
// as the request. Slaves signal not-ready through slv_busy; a slave strobe
// (slv_load/slv_rd) is only raised in a cycle where that slave's slv_busy is low.
interface mem_router_if #(
   parameter int NUM_SLV = 3,
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16
);
   logic [ADDR_W-1:0]         address;
   logic [DATA_W-1:0]         in;
   logic                      load;
   logic                      rd;
   logic                      busy;
   logic [DATA_W-1:0]         out;
   logic                      out_valid;
   logic                      err;

   logic [ADDR_W-1:0]         slv_addr;
   logic [DATA_W-1:0]         slv_din;
   logic [NUM_SLV-1:0]        slv_load;
   logic [NUM_SLV-1:0]        slv_rd;
   logic [NUM_SLV-1:0]        slv_busy;
   logic [NUM_SLV*DATA_W-1:0] slv_dout;

   // Environment side: the CPU issuing requests and the slaves answering them.
   modport master (
      output address, in, load, rd, slv_busy, slv_dout,
      input  busy, out, out_valid, err, slv_addr, slv_din, slv_load, slv_rd
   );

   // Router side.
   modport slave (
      input  address, in, load, rd, slv_busy, slv_dout,
      output busy, out, out_valid, err, slv_addr, slv_din, slv_load, slv_rd
   );
endinterface

// File: rtl/mem_router_addr_decode.sv
// Combinational address decoder: per-slot hit test, lowest index wins,
// no hit means the address is unmapped.
module addr_decode
   import mem_router_pkg::*;
#(
   parameter int                        NUM_SLV  = 3,
   parameter int                        ADDR_W   = 16,
   parameter int                        IW       = slot_w(NUM_SLV),
   parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = {16'h6000, 16'h4000, 16'h0000},
   parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = {16'hFFFF, 16'hE000, 16'hC000}
) (
   input  logic [ADDR_W-1:0]  addr,
   output logic               hit,
   output logic [IW-1:0]      idx,
   output logic [NUM_SLV-1:0] sel
);

   // Scan from the top slot down so the lowest matching slot is the last write.
   always_comb begin
      hit = 1'b0;
      idx = '0;
      sel = '0;
      for (int i = NUM_SLV - 1; i >= 0; i--) begin
         if ((addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
            hit    = 1'b1;
            idx    = IW'(i);
            sel    = '0;
            sel[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_router.sv
// Memory router: decodes CPU accesses onto NUM_SLV slaves, posts writes to a
// busy slave in a one-entry buffer and returns reads after RD_LAT cycles.
module mem_router
   import mem_router_pkg::*;
#(
   parameter int                        NUM_SLV  = 3,
   parameter int                        ADDR_W   = 16,
   parameter int                        DATA_W   = 16,
   parameter int                        RD_LAT   = 1,
   parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = {16'h6000, 16'h4000, 16'h0000},
   parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = {16'hFFFF, 16'hE000, 16'hC000}
) (
   input  logic           clk,
   input  logic           rst,
   mem_router_if.slave    bus,
   output wr_state_t      dbg_state
);

   localparam int IW = slot_w(NUM_SLV);

   if (NUM_SLV < 1 || NUM_SLV > MAX_SLV) begin : g_bad_num_slv
      $error("mem_router: NUM_SLV must be in 1..%0d", MAX_SLV);
   end
   if (RD_LAT < 1 || RD_LAT > MAX_RD_LAT) begin : g_bad_rd_lat
      $error("mem_router: RD_LAT must be in 1..%0d", MAX_RD_LAT);
   end

   logic               cpu_hit;
   logic [IW-1:0]      cpu_idx;
   logic [NUM_SLV-1:0] cpu_sel;

   addr_decode #(
      .NUM_SLV  (NUM_SLV),
      .ADDR_W   (ADDR_W),
      .IW       (IW),
      .SLV_BASE (SLV_BASE),
      .SLV_MASK (SLV_MASK)
   ) u_decode (
      .addr (bus.address),
      .hit  (cpu_hit),
      .idx  (cpu_idx),
      .sel  (cpu_sel)
   );

   wr_state_t            state;
   logic [ADDR_W-1:0]    b_addr;
   logic [DATA_W-1:0]    b_data;
   logic [NUM_SLV-1:0]   b_sel;
   // Set once the write half of a combined load+rd has been taken, so the
   // held load is not replayed while the read half waits its turn.
   logic                 wr_done;

   logic [RD_LAT-1:0]          pipe_v;
   logic [RD_LAT-1:0]          pipe_hit;
   logic [RD_LAT-1:0][IW-1:0]  pipe_idx;

   logic               tgt_busy, buf_busy, wr_req, rd_req;
   logic               capture, issue;
   logic               busy_c, err_c;
   logic [ADDR_W-1:0]  slv_addr_c;
   logic [DATA_W-1:0]  slv_din_c;
   logic [NUM_SLV-1:0] slv_load_c, slv_rd_c;
   logic [DATA_W-1:0]  out_c;
   logic               out_valid_c;

   assign tgt_busy = |(cpu_sel & bus.slv_busy);
   assign buf_busy = |(b_sel & bus.slv_busy);
   assign wr_req   = bus.load && !wr_done;
   assign rd_req   = bus.rd && !wr_req;

   // Request steering: posted write drains first, then writes beat reads.
   always_comb begin
      slv_addr_c = bus.address;
      slv_din_c  = bus.in;
      slv_load_c = '0;
      slv_rd_c   = '0;
      busy_c     = 1'b0;
      err_c      = 1'b0;
      capture    = 1'b0;
      issue      = 1'b0;
      if (!rst) begin
         if (state == WR_POSTED) begin
            slv_addr_c = b_addr;
            slv_din_c  = b_data;
            slv_load_c = buf_busy ? '0 : b_sel;
            busy_c     = bus.load || bus.rd;
         end else if (wr_req) begin
            if (!cpu_hit)      err_c      = 1'b1;
            else if (tgt_busy) capture    = 1'b1;
            else               slv_load_c = cpu_sel;
            busy_c = bus.rd;
         end else if (rd_req) begin
            if (!cpu_hit) begin
               err_c = 1'b1;
               issue = 1'b1;
            end else if (tgt_busy) begin
               busy_c = 1'b1;
            end else begin
               slv_rd_c = cpu_sel;
               issue    = 1'b1;
            end
         end
      end
   end

   // Write-path FSM with its buffer and the combined-access bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= WR_IDLE;
         b_sel   <= '0;
         wr_done <= 1'b0;
      end else begin
         case (state)
            WR_IDLE: begin
               if (capture) begin
                  state  <= WR_POSTED;
                  b_addr <= bus.address;
                  b_data <= bus.in;
                  b_sel  <= cpu_sel;
               end
            end
            WR_POSTED: begin
               if (!buf_busy) state <= WR_IDLE;
            end
            default: state <= WR_IDLE;
         endcase
         if (issue)
            wr_done <= 1'b0;
         else if (state == WR_IDLE && wr_req && bus.rd)
            wr_done <= 1'b1;
      end
   end

   // Read pipeline: slot index and mapped flag travel RD_LAT stages deep.
   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_v <= '0;
      end else begin
         pipe_v[0] <= issue;
         for (int i = RD_LAT - 1; i > 0; i--) pipe_v[i] <= pipe_v[i-1];
      end
      pipe_hit[0] <= cpu_hit;
      pipe_idx[0] <= cpu_idx;
      for (int i = RD_LAT - 1; i > 0; i--) begin
         pipe_hit[i] <= pipe_hit[i-1];
         pipe_idx[i] <= pipe_idx[i-1];
      end
   end

   // Read return: select the tail slot's data; unmapped reads return zero.
   always_comb begin
      out_c       = '0;
      out_valid_c = !rst && pipe_v[RD_LAT-1];
      if (out_valid_c && pipe_hit[RD_LAT-1]) begin
         for (int i = 0; i < NUM_SLV; i++) begin
            if (pipe_idx[RD_LAT-1] == IW'(i)) out_c = bus.slv_dout[i*DATA_W +: DATA_W];
         end
      end
   end

   assign bus.busy      = busy_c;
   assign bus.err       = err_c;
   assign bus.out       = out_c;
   assign bus.out_valid = out_valid_c;
   assign bus.slv_addr  = slv_addr_c;
   assign bus.slv_din   = slv_din_c;
   assign bus.slv_load  = slv_load_c;
   assign bus.slv_rd    = slv_rd_c;
   assign dbg_state     = state;

endmodule

// File: tb/tb_mem_router.sv
// Directed bench for mem_router (RD_LAT=2, default map) with a write and
// read scoreboard fed by the stimulus and drained by a monitor.
module tb_mem_router;
   import mem_router_pkg::*;

   localparam int NS = 3;
   localparam int AW = 16;
   localparam int DW = 16;
   localparam int RL = 2;

   logic      clk = 1'b0;
   logic      rst;
   wr_state_t dbg_state;

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0]         exp_q[$];
   logic [NS+AW+DW-1:0]   exp_w_q[$];

   mem_router_if #(.NUM_SLV(NS), .ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_router #(.NUM_SLV(NS), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // Clock.
   always #5 clk = ~clk;

   // Slave model: every slot returns {slot+1, addr[11:0]} of the address on
   // the shared bus RD_LAT cycles earlier.
   logic [RL-1:0][AW-1:0] addr_sh;
   always_ff @(posedge clk) begin
      addr_sh[0] <= bus.slv_addr;
      for (int i = 1; i < RL; i++) addr_sh[i] <= addr_sh[i-1];
   end
   always_comb begin
      for (int i = 0; i < NS; i++) bus.slv_dout[i*DW +: DW] = {4'(i + 1), addr_sh[RL-1][11:0]};
   end

   task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops the scoreboards whenever the DUT presents a write or read data.
   always @(negedge clk) begin
      if (bus.slv_load != '0) begin
         if (exp_w_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write: got %0h expected none", {bus.slv_load, bus.slv_addr, bus.slv_din});
         end else begin
            check_eq("slave_write", {bus.slv_load, bus.slv_addr, bus.slv_din}, exp_w_q.pop_front());
         end
      end
      if (bus.out_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_read: got %0h expected none", bus.out);
         end else begin
            check_eq("read_data", bus.out, exp_q.pop_front());
         end
      end else begin
         check_eq("out_idle_zero", bus.out, '0);
      end
   end

   // Watchdog.
   initial begin
      #100000;
      failures++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      rst = 1'b1;
      bus.address  = '0;
      bus.in       = '0;
      bus.load     = 1'b0;
      bus.rd       = 1'b0;
      bus.slv_busy = '0;

      // Reset.
      next(); next();
      @(negedge clk);
      check_eq("rst_busy", bus.busy, 0);
      check_eq("rst_out_valid", bus.out_valid, 0);
      check_eq("rst_slv_load", bus.slv_load, 0);
      check_eq("rst_slv_rd", bus.slv_rd, 0);
      check_eq("rst_err", bus.err, 0);
      next(); rst = 1'b0;
      @(negedge clk);
      check_eq("post_rst_state", dbg_state, WR_IDLE);

      // Pass-through write to slot 0.
      next(); bus.address = 16'h0005; bus.in = 16'h1234; bus.load = 1'b1;
      exp_w_q.push_back({3'b001, 16'h0005, 16'h1234});
      @(negedge clk);
      check_eq("wr_pass_busy", bus.busy, 0);
      check_eq("wr_pass_err", bus.err, 0);
      next(); bus.load = 1'b0;
      @(negedge clk);
      check_eq("wr_pass_busy_after", bus.busy, 0);

      // Three back-to-back reads to slots 0,1,2.
      next(); bus.rd = 1'b1; bus.address = 16'h0001; exp_q.push_back(16'h1001);
      @(negedge clk);
      check_eq("rd0_slv_rd", bus.slv_rd, 3'b001);
      check_eq("rd0_busy", bus.busy, 0);
      check_eq("rd_c0_valid", bus.out_valid, 0);
      next(); bus.address = 16'h4000; exp_q.push_back(16'h2000);
      @(negedge clk);
      check_eq("rd1_slv_rd", bus.slv_rd, 3'b010);
      check_eq("rd_c1_valid", bus.out_valid, 0);
      next(); bus.address = 16'h6000; exp_q.push_back(16'h3000);
      @(negedge clk);
      check_eq("rd2_slv_rd", bus.slv_rd, 3'b100);
      check_eq("rd_c2_valid", bus.out_valid, 1);
      next(); bus.rd = 1'b0;
      @(negedge clk);
      check_eq("rd_c3_valid", bus.out_valid, 1);
      next();
      @(negedge clk);
      check_eq("rd_c4_valid", bus.out_valid, 1);
      next();
      @(negedge clk);
      check_eq("rd_c5_valid", bus.out_valid, 0);

      // Posted write to a busy slot 1, then a read held off until it drains.
      next(); bus.slv_busy = 3'b010; bus.load = 1'b1; bus.address = 16'h4010; bus.in = 16'hBEEF;
      exp_w_q.push_back({3'b010, 16'h4010, 16'hBEEF});
      @(negedge clk);
      check_eq("post_accept_busy", bus.busy, 0);
      check_eq("post_accept_load", bus.slv_load, 0);
      next(); bus.load = 1'b0; bus.rd = 1'b1; bus.address = 16'h0000;
      @(negedge clk);
      check_eq("post_c1_busy", bus.busy, 1);
      check_eq("post_c1_state", dbg_state, WR_POSTED);
      check_eq("post_c1_addr", bus.slv_addr, 16'h4010);
      check_eq("post_c1_rd", bus.slv_rd, 0);
      next();
      @(negedge clk);
      check_eq("post_c2_busy", bus.busy, 1);
      next(); bus.slv_busy = 3'b000;
      @(negedge clk);
      check_eq("post_c3_busy", bus.busy, 1);
      check_eq("post_c3_rd", bus.slv_rd, 0);
      next(); exp_q.push_back(16'h1000);
      @(negedge clk);
      check_eq("post_c4_busy", bus.busy, 0);
      check_eq("post_c4_rd", bus.slv_rd, 3'b001);
      check_eq("post_c4_state", dbg_state, WR_IDLE);
      next(); bus.rd = 1'b0;

      // Unmapped read and unmapped write.
      next(); bus.rd = 1'b1; bus.address = 16'h7000; exp_q.push_back(16'h0000);
      @(negedge clk);
      check_eq("unm_rd_err", bus.err, 1);
      check_eq("unm_rd_busy", bus.busy, 0);
      check_eq("unm_rd_slv_rd", bus.slv_rd, 0);
      next(); bus.rd = 1'b0;
      @(negedge clk);
      check_eq("unm_rd_err_drop", bus.err, 0);
      next(); bus.load = 1'b1; bus.address = 16'h8000; bus.in = 16'hFFFF;
      @(negedge clk);
      check_eq("unm_rd_ret_valid", bus.out_valid, 1);
      check_eq("unm_wr_err", bus.err, 1);
      check_eq("unm_wr_busy", bus.busy, 0);
      next(); bus.load = 1'b0;

      // Read to a busy slot retries until it is free.
      next(); bus.slv_busy = 3'b100; bus.rd = 1'b1; bus.address = 16'h6000;
      @(negedge clk);
      check_eq("retry_busy", bus.busy, 1);
      check_eq("retry_no_rd", bus.slv_rd, 0);
      next(); bus.slv_busy = 3'b000; exp_q.push_back(16'h3000);
      @(negedge clk);
      check_eq("retry_issue_busy", bus.busy, 0);
      check_eq("retry_issue_rd", bus.slv_rd, 3'b100);
      next(); bus.rd = 1'b0;

      // load and rd together: write first, read the next cycle.
      next(); bus.load = 1'b1; bus.rd = 1'b1; bus.address = 16'h0002; bus.in = 16'h5A5A;
      exp_w_q.push_back({3'b001, 16'h0002, 16'h5A5A});
      @(negedge clk);
      check_eq("both_busy", bus.busy, 1);
      check_eq("both_no_rd", bus.slv_rd, 0);
      next(); exp_q.push_back(16'h1002);
      @(negedge clk);
      check_eq("both_rd_busy", bus.busy, 0);
      check_eq("both_rd_issue", bus.slv_rd, 3'b001);
      next(); bus.load = 1'b0; bus.rd = 1'b0;

      // Reset while a write is posted and a read is in flight.
      next(); bus.rd = 1'b1; bus.address = 16'h4004;
      @(negedge clk);
      check_eq("flight_rd", bus.slv_rd, 3'b010);
      next(); bus.rd = 1'b0; bus.load = 1'b1; bus.address = 16'h0010; bus.in = 16'h1111;
      bus.slv_busy = 3'b001;
      @(negedge clk);
      check_eq("flight_post_busy", bus.busy, 0);
      next(); bus.load = 1'b0; rst = 1'b1;
      @(negedge clk);
      check_eq("mid_rst_valid", bus.out_valid, 0);
      check_eq("mid_rst_load", bus.slv_load, 0);
      check_eq("mid_rst_busy", bus.busy, 0);
      next(); rst = 1'b0; bus.slv_busy = 3'b000;
      @(negedge clk);
      check_eq("after_rst_state", dbg_state, WR_IDLE);
      check_eq("after_rst_valid", bus.out_valid, 0);
      check_eq("after_rst_load", bus.slv_load, 0);
      next();
      @(negedge clk);
      check_eq("after_rst2_valid", bus.out_valid, 0);

      // Drain and report.
      repeat (4) next();
      @(negedge clk);
      check_eq("read_queue_empty", exp_q.size(), 0);
      check_eq("write_queue_empty", exp_w_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_router.md
MEM_ROUTER -- requirements
Module: mem_router

Interface
REQ-001 Parameter NUM_SLV, default 3: number of slave ports, 1..8.
REQ-002 Parameter ADDR_W, default 16: CPU address width.
REQ-003 Parameter DATA_W, default 16: data width.
REQ-004 Parameter RD_LAT, default 1: slave read latency in cycles, 1..4, common to all slaves.
REQ-005 Parameter SLV_BASE, default {16'h6000,16'h4000,16'h0000}: packed NUM_SLV*ADDR_W region bases; slot i at bits [i*ADDR_W +: ADDR_W].
REQ-006 Parameter SLV_MASK, default {16'hFFFF,16'hE000,16'hC000}: packed region masks; address hits slot i when (addr & MASK_i) == BASE_i.
REQ-007 Clock and reset: one clock; reset is synchronous and active-high.
REQ-008 clk  in  1  single clock; all state on rising edge.
REQ-009 rst  in  1  synchronous active-high reset.
REQ-010 address  in  ADDR_W  CPU address.
REQ-011 in  in  DATA_W  CPU write data.
REQ-012 load  in  1  CPU write strobe.
REQ-013 rd  in  1  CPU read strobe.
REQ-014 busy  out  1  CPU must hold address/in/load/rd while high.
REQ-015 out  out  DATA_W  read data.
REQ-016 out_valid  out  1  out holds data for a read issued RD_LAT cycles earlier.
REQ-017 err  out  1  one-cycle pulse on an accepted access to an unmapped address.
REQ-018 slv_addr  out  ADDR_W  shared slave address.
REQ-019 slv_din  out  DATA_W  shared slave write data.
REQ-020 slv_load  out  NUM_SLV  per-slave write strobe.
REQ-021 slv_rd  out  NUM_SLV  per-slave read strobe.
REQ-022 slv_busy  in  NUM_SLV  per-slave not-ready.
REQ-023 slv_dout  in  NUM_SLV*DATA_W  packed slave read data.

Function
REQ-024 Decode: hit vector per REQ-006; lowest hitting index wins; no hit = unmapped.
REQ-025 Write path FSM states IDLE, POSTED; one-entry write buffer (addr, data, slot).
REQ-026 IDLE, load, target not busy: same-cycle pass-through on slv_load/slv_addr/slv_din; busy=0.
REQ-027 IDLE, load, target busy: capture into buffer, go POSTED; busy=0 that cycle (write accepted).
REQ-028 POSTED: drive buffer onto slave bus; assert slv_load of buffered slot every cycle its slv_busy is low; return to IDLE the cycle it is low.
REQ-029 POSTED: busy=1 for any CPU load or rd; no CPU access issued (preserves ordering).
REQ-030 Read issue: rd, IDLE, target not busy: slv_rd pulses for one cycle, index and valid enter RD_LAT-deep pipeline.
REQ-031 Read to busy target in IDLE: busy=1, no issue, retry each cycle.
REQ-032 Read return: pipeline tail valid -> out_valid=1, out = slv_dout of tail index; else out_valid=0, out=0.
REQ-033 Unmapped write: discarded, err pulses, busy=0. Unmapped read: accepted, pipeline carries unmapped tag, out=0 with out_valid=1 at RD_LAT, err pulses at issue.
REQ-034 load and rd together: write takes priority; read treated as not presented, busy=1 that cycle.
REQ-035 Back-to-back reads to different slaves: one issued per cycle, returns in order, no bubbles.
REQ-036 slv_load/slv_rd are one-hot or zero; slv_addr/slv_din = CPU inputs except in POSTED.

Reset
REQ-037 rst: FSM to IDLE, buffer valid cleared, read pipeline valids cleared, in-flight reads and pending write dropped.
REQ-038 During and in cycle after rst: busy=0, out=0, out_valid=0, err=0, slv_load=0, slv_rd=0.

Structure
REQ-039 Shared package mem_router_pkg: FSM state encoding, MAX_SLV=8, MAX_RD_LAT=4, slot-index width function.
REQ-040 One sub-module addr_decode: combinational hit/priority/unmapped from address, SLV_BASE, SLV_MASK.
REQ-041 Elaboration error if NUM_SLV or RD_LAT out of range.

Verification
REQ-042 Defaults, write 0x1234 to 0x0005, slv_busy=0 -> slv_load=3'b001 same cycle, busy never high.
REQ-043 RD_LAT=2, reads 0x0001, 0x4000, 0x6000 consecutive -> out_valid cycles 2..4, data from slots 0,1,2 in order.
REQ-044 slv_busy[1]=1 for 3 cycles, write 0x4010 then read 0x0000 -> write posted, busy=1 three cycles, slv_load[1] pulse at cycle 3, read issues cycle 4.
REQ-045 Read 0x7000 with SLV_MASK slot2=16'hFFFF -> err pulse, out=0, out_valid=1 after RD_LAT.
REQ-046 rst asserted while POSTED with read in flight -> next cycle IDLE, out_valid=0, no slv_load.
REQ-047 load=1 and rd=1 same cycle to 0x0002 -> write performed, busy=1, read issued next cycle.
